tex_texel_fetch: RTL
====================

// Module: tex_texel_fetch
// PURPOSE
// Texel fetch stage directly upstream of the texture sampler. Takes one request of
// NUM_REQS lanes x 4 texel addresses, issues one-word memory reads for active lanes,
// gathers out-of-order responses by tag, then presents the 4 raw texels per lane,
// plus format/blends/info, to the sampler over a valid/ready handshake.
// PARAMETERS
// CORE_ID    0   core index; unused in logic
// NUM_REQS   1   lanes per request
// REQ_INFOW  1   opaque request info width, passed through
// ADDRW      32  memory word address width
// TAGW       $clog2(NUM_REQS*4) (min 1)  memory tag width = texel slot index
// PORTS
// clk            in   1                        clock
// reset          in   1                        asynchronous, active-low reset
// req_valid      in   1                        fetch request valid
// req_tmask      in   NUM_REQS                 active lanes
// req_format     in   `TEX_FORMAT_BITS         texel format, passed through
// req_blends     in   NUM_REQS*2*`TEX_BLEND_FRAC  u/v blend fractions, passed through
// req_addr       in   NUM_REQS*4*ADDRW         texel addresses, slot s = lane*4+j
// req_info       in   REQ_INFOW                passed through
// req_ready      out  1                        request accepted when valid&ready
// mem_req_valid  out  1                        memory read valid
// mem_req_addr   out  ADDRW                    read address
// mem_req_tag    out  TAGW                     slot index s
// mem_req_ready  in   1                        memory accepts read
// mem_rsp_valid  in   1                        read data valid
// mem_rsp_data   in   32                       texel word
// mem_rsp_tag    in   TAGW                     slot index of returned word
// mem_rsp_ready  out  1                        = busy (ISSUE or WAIT)
// rsp_valid      out  1                        texels ready for sampler
// rsp_tmask/rsp_format/rsp_blends/rsp_info  out  as req_*  registered copies
// rsp_data       out  NUM_REQS*4*32            gathered texels
// rsp_ready      in   1                        sampler accepts
// BEHAVIOUR
// - Reset (reset=0, async): state IDLE; req_ready=1 after reset, mem_req_valid=0,
//   rsp_valid=0, all data/tag/mask/pending registers 0.
// - FSM IDLE: req_ready=1; on req_valid latch all req_* fields, build issue mask
//   (slot s set iff tmask[s/4]), clear pending/data -> ISSUE, or -> OUT if mask empty.
// - ISSUE: mem_req_valid=1 for lowest set issue-mask slot; on mem_req_ready clear that
//   bit, set pending[s]; when last bit leaves -> WAIT (or OUT if pending already empty).
// - WAIT: -> OUT the cycle after pending becomes zero.
// - mem_rsp accepted in ISSUE/WAIT: data[tag]<=mem_rsp_data, pending[tag]<=0. Same-cycle
//   issue of slot a and response for slot b both take effect (a!=b guaranteed by tags).
// - Response with tag not pending, or in IDLE/OUT: mem_rsp_ready=0 in IDLE/OUT; in
//   ISSUE/WAIT a non-pending tag is dropped (data unchanged).
// - OUT: rsp_valid=1, outputs stable until rsp_ready; on valid&ready -> IDLE, rsp_valid=0
//   next cycle. One request in flight; req_ready=0 outside IDLE.
// - Inactive-lane rsp_data words are 0. Min latency accept->rsp_valid: 1 cycle (empty
//   mask); else issue_count + memory latency + 1.
// - reset asserted mid-operation: abort immediately to reset state; late memory
//   responses after reset are refused (mem_rsp_ready=0 in IDLE).
// CONFIGURATION
// TEX_FETCH_COALESCE_EN defined: for j=1..3, slot lane*4+j whose address equals the
//   lane's slot 0 address is not issued; it is marked alias and written with the same
//   data when slot 0's response is accepted. Issue count per lane may drop to 1.
// Undefined: every active slot issued, no address compare logic.
// TESTING
// 1 NUM_REQS=1, addrs 0x10..0x13, in-order rsp 0xA,0xB,0xC,0xD -> 4 issues tags 0..3,
//   rsp_data={0xD,0xC,0xB,0xA}, rsp_valid held until rsp_ready.
// 2 NUM_REQS=2, tmask=2'b10 -> only tags 4..7 issued; lane0 rsp_data all 0.
// 3 Responses in order tags 3,0,2,1 with mem_req_ready toggling 1/0 -> correct slot
//   placement, no lost or duplicated issue.
// 4 tmask=0 -> zero mem requests, rsp_valid 1 cycle after accept.
// 5 reset low during WAIT with 2 pending -> outputs 0 immediately; later rsp refused,
//   next request completes normally.
// 6 COALESCE_EN, lane addrs all 0x40, rsp 0x1234 -> 1 issue, 4 words = 0x1234;
//   without macro -> 4 issues.

Source files
------------

// File: rtl/tex_texel_fetch.sv
// Texel fetch stage: issues one-word reads for the active lanes' texel slots, gathers
// tagged out-of-order responses and hands 4 raw texels per lane to the sampler.
// Optional: define TEX_FETCH_COALESCE_EN to skip reads whose address repeats the lane's slot 0.

`ifndef TEX_FORMAT_BITS
`define TEX_FORMAT_BITS 3
`endif
`ifndef TEX_BLEND_FRAC
`define TEX_BLEND_FRAC 8
`endif

module tex_texel_fetch #(
  parameter int CORE_ID   = 0,
  parameter int NUM_REQS  = 1,
  parameter int REQ_INFOW = 1,
  parameter int ADDRW     = 32,
  parameter int TAGW      = (NUM_REQS * 4 > 1) ? $clog2(NUM_REQS * 4) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,

  input  logic                                  req_valid,
  input  logic [NUM_REQS-1:0]                   req_tmask,
  input  logic [`TEX_FORMAT_BITS-1:0]           req_format,
  input  logic [NUM_REQS*2*`TEX_BLEND_FRAC-1:0] req_blends,
  input  logic [NUM_REQS*4*ADDRW-1:0]           req_addr,
  input  logic [REQ_INFOW-1:0]                  req_info,
  output logic                                  req_ready,

  output logic                                  mem_req_valid,
  output logic [ADDRW-1:0]                      mem_req_addr,
  output logic [TAGW-1:0]                       mem_req_tag,
  input  logic                                  mem_req_ready,

  input  logic                                  mem_rsp_valid,
  input  logic [31:0]                           mem_rsp_data,
  input  logic [TAGW-1:0]                       mem_rsp_tag,
  output logic                                  mem_rsp_ready,

  output logic                                  rsp_valid,
  output logic [NUM_REQS-1:0]                   rsp_tmask,
  output logic [`TEX_FORMAT_BITS-1:0]           rsp_format,
  output logic [NUM_REQS*2*`TEX_BLEND_FRAC-1:0] rsp_blends,
  output logic [NUM_REQS*4*32-1:0]              rsp_data,
  output logic [REQ_INFOW-1:0]                  rsp_info,
  input  logic                                  rsp_ready
);

  localparam int NUM_SLOTS = NUM_REQS * 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t                          state;
  logic [NUM_SLOTS-1:0]            issue_mask;
  logic [NUM_SLOTS-1:0]            pending;
  logic [NUM_SLOTS-1:0][ADDRW-1:0] addr_q;
  logic [NUM_SLOTS-1:0][31:0]      data_q;

  logic [NUM_SLOTS-1:0]            new_issue;
  logic [NUM_SLOTS-1:0]            issue_nxt;
  logic [NUM_SLOTS-1:0]            pending_nxt;
  logic [NUM_SLOTS-1:0][31:0]      data_nxt;
  logic [TAGW-1:0]                 issue_sel;
  logic                            busy;
  logic                            mem_req_fire;
  logic                            rsp_hit;

`ifdef TEX_FETCH_COALESCE_EN
  logic [NUM_SLOTS-1:0][ADDRW-1:0] req_addr_a;
  logic [NUM_SLOTS-1:0]            new_alias;
  logic [NUM_SLOTS-1:0]            alias_q;

  assign req_addr_a = req_addr;
`endif

  assign busy          = (state == S_ISSUE) || (state == S_WAIT);
  assign req_ready     = (state == S_IDLE);
  assign rsp_valid     = (state == S_OUT);
  assign mem_req_valid = (state == S_ISSUE);
  assign mem_rsp_ready = busy;
  assign mem_req_addr  = addr_q[issue_sel];
  assign mem_req_tag   = issue_sel;
  assign mem_req_fire  = mem_req_valid && mem_req_ready;
  assign rsp_data      = data_q;

  // Responses for slots that are not outstanding are consumed but leave the data untouched.
  assign rsp_hit = busy && mem_rsp_valid && (int'(mem_rsp_tag) < NUM_SLOTS) && pending[mem_rsp_tag];

  // NOTE: every signal written in an always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    new_issue = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      new_issue[s] = req_tmask[s / 4];
    end
`ifdef TEX_FETCH_COALESCE_EN
    new_alias = '0;
    for (int l = 0; l < NUM_REQS; l++) begin
      for (int j = 1; j < 4; j++) begin
        if (req_tmask[l] && (req_addr_a[l*4+j] == req_addr_a[l*4])) begin
          new_issue[l*4+j] = 1'b0;
          new_alias[l*4+j] = 1'b1;
        end
      end
    end
`endif
  end

  // Lowest set slot of the issue mask goes out first.
  always_comb begin
    issue_sel = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (issue_mask[s]) issue_sel = TAGW'(s);
    end
  end

  always_comb begin
    issue_nxt   = issue_mask;
    pending_nxt = pending;
    if (mem_req_fire) begin
      issue_nxt[issue_sel]   = 1'b0;
      pending_nxt[issue_sel] = 1'b1;
    end
    if (rsp_hit) pending_nxt[mem_rsp_tag] = 1'b0;
  end

  always_comb begin
    data_nxt = data_q;
    if (rsp_hit) begin
      data_nxt[mem_rsp_tag] = mem_rsp_data;
`ifdef TEX_FETCH_COALESCE_EN
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (alias_q[s] && ((s / 4) * 4 == int'(mem_rsp_tag))) data_nxt[s] = mem_rsp_data;
      end
`endif
    end
  end

  // NOTE: sequential state is assigned with <= only, so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      issue_mask <= '0;
      pending    <= '0;
      addr_q     <= '0;
      // NOTE: the texel store is small and must read back as zero after reset, so it
      // is a reset register bank rather than an unreset RAM.
      data_q     <= '0;
      rsp_tmask  <= '0;
      rsp_format <= '0;
      rsp_blends <= '0;
      rsp_info   <= '0;
`ifdef TEX_FETCH_COALESCE_EN
      alias_q    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            rsp_tmask  <= req_tmask;
            rsp_format <= req_format;
            rsp_blends <= req_blends;
            rsp_info   <= req_info;
            addr_q     <= req_addr;
            issue_mask <= new_issue;
            pending    <= '0;
            data_q     <= '0;
`ifdef TEX_FETCH_COALESCE_EN
            alias_q    <= new_alias;
`endif
            state      <= (|new_issue) ? S_ISSUE : S_OUT;
          end
        end
        S_ISSUE, S_WAIT: begin
          issue_mask <= issue_nxt;
          pending    <= pending_nxt;
          data_q     <= data_nxt;
          if (issue_nxt == '0) state <= (pending_nxt == '0) ? S_OUT : S_WAIT;
        end
        S_OUT: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
